// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the ram_arb fetch/data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned RAM_BYTES = 4;

endpackage

// File: rtl/ram_arb_align.sv
// Combinational data-port lane logic: store alignment, byte enables,
// load extraction with sign/zero extension, and misalignment detection.
module ram_arb_align
  import ram_arb_pkg::*;
(
  input  logic [1:0]           i_size,
  input  logic                 i_signed,
  input  logic [1:0]           i_off,
  input  logic [31:0]          i_wr_data,
  input  logic [31:0]          i_rd_data,
  output logic [RAM_BYTES-1:0] o_be,
  output logic [31:0]          o_wr_lanes,
  output logic [31:0]          o_rd_data,
  output logic                 o_misalign
);

  logic [4:0]  w_shift;
  logic [31:0] w_rd_sh;

  assign w_shift = {i_off, 3'b000};
  assign w_rd_sh = i_rd_data >> w_shift;

  always_comb begin
    o_be       = '0;
    o_wr_lanes = '0;
    o_rd_data  = '0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be       = 4'b0001 << i_off;
        o_wr_lanes = {24'b0, i_wr_data[7:0]} << w_shift;
        o_rd_data  = {{24{i_signed & w_rd_sh[7]}}, w_rd_sh[7:0]};
      end
      SZ_H: begin
        o_misalign = i_off[0];
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_wr_lanes = {16'b0, i_wr_data[15:0]} << w_shift;
        o_rd_data  = {{16{i_signed & w_rd_sh[15]}}, w_rd_sh[15:0]};
      end
      SZ_W: begin
        o_misalign = |i_off;
        o_be       = '1;
        o_wr_lanes = i_wr_data;
        o_rd_data  = i_rd_data;
      end
      default: o_misalign = 1'b1;
    endcase
    // A misaligned access never writes and always returns zero data.
    if (o_misalign) begin
      o_be      = '0;
      o_rd_data = '0;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Single-port RAM arbiter between an instruction fetch port and a data port.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is data priority.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     IReq,
  input  logic [31:0]              IAddr,
  output logic                     IGnt,
  output logic                     IRspVld,
  output logic [RAM_WIDTH-1:0]     IRspData,
  input  logic                     DReq,
  input  logic                     DWe,
  input  logic [1:0]               DSize,
  input  logic                     DSigned,
  input  logic [31:0]              DAddr,
  input  logic [RAM_WIDTH-1:0]     DWrData,
  output logic                     DGnt,
  output logic                     DRspVld,
  output logic [RAM_WIDTH-1:0]     DRspData,
  output logic                     DErr,
  output logic [RAM_BYTES-1:0]     RamWrEn,
  output logic [RAM_ADDR_BITS-1:0] RamAddr,
  output logic [RAM_WIDTH-1:0]     RamWrData,
  input  logic [RAM_WIDTH-1:0]     RamRdData
);

  logic                 w_ireq;
  logic                 w_dreq;
  logic                 w_dwin;
  logic [RAM_BYTES-1:0] w_be;
  logic [31:0]          w_rdata;
  logic                 w_mis;
  logic                 w_unused;

  logic                 r_ivld;
  logic                 r_dvld;
  logic                 r_derr;
  logic [31:0]          r_idata;
  logic [31:0]          r_ddata;

  assign w_ireq = IReq & ~Rst;
  assign w_dreq = DReq & ~Rst;

`ifdef RAM_ARB_RR_EN
  owner_e r_last;
  owner_e w_last_nxt;
  logic   w_same_word;

  // A store to the word being fetched must win so the fetch sees the new data.
  assign w_same_word = DAddr[RAM_ADDR_BITS+1:2] == IAddr[RAM_ADDR_BITS+1:2];
  assign w_dwin = w_dreq & (~w_ireq | (r_last == OWN_I) | (DWe & w_same_word));

  always_comb begin
    w_last_nxt = r_last;
    if (w_dwin)
      w_last_nxt = OWN_D;
    else if (w_ireq)
      w_last_nxt = OWN_I;
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      r_last <= OWN_I;
    else
      r_last <= w_last_nxt;
  end
`else
  assign w_dwin = w_dreq;
`endif

  assign DGnt    = w_dwin;
  assign IGnt    = w_ireq & ~w_dwin;
  assign RamAddr = w_dwin ? DAddr[RAM_ADDR_BITS+1:2] : IAddr[RAM_ADDR_BITS+1:2];
  assign RamWrEn = (w_dwin & DWe) ? w_be : '0;

  ram_arb_align u_align (
    .i_size     (DSize),
    .i_signed   (DSigned),
    .i_off      (DAddr[1:0]),
    .i_wr_data  (DWrData),
    .i_rd_data  (RamRdData),
    .o_be       (w_be),
    .o_wr_lanes (RamWrData),
    .o_rd_data  (w_rdata),
    .o_misalign (w_mis)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ivld  <= 1'b0;
      r_dvld  <= 1'b0;
      r_derr  <= 1'b0;
      r_idata <= '0;
      r_ddata <= '0;
    end else begin
      r_ivld <= IGnt;
      r_dvld <= w_dwin;
      r_derr <= w_dwin & w_mis;
      if (IGnt)
        r_idata <= RamRdData;
      if (w_dwin)
        r_ddata <= w_rdata;
    end
  end

  // Valids are masked by Rst so a response already registered is squashed.
  assign IRspVld  = r_ivld & ~Rst;
  assign DRspVld  = r_dvld & ~Rst;
  assign DErr     = r_derr & ~Rst;
  assign IRspData = r_idata;
  assign DRspData = r_ddata;

  assign w_unused = ^{IAddr[1:0], IAddr[31:RAM_ADDR_BITS+2], DAddr[31:RAM_ADDR_BITS+2]};

endmodule
